maze_frame_driver: RTL

- Host/bench-side peer of the maze solver.
- Holds a 15x15 maze image written row by row, then serializes it onto the solver's input pins as `maze`/`in_valid`.
- Captures the solver's answer stream (`out_valid`, `maze_not_valid`, `out_x`, `out_y`) and checks it against the stored image on the fly.
- Reports a pass/fail verdict, path length and error flags, so regression runs need no scoreboard of their own.

---
 rtl/maze_frame_driver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/maze_frame_driver.sv
// Host-side peer of the maze solver: stores a 15x15 image, serializes it, then checks the answer path.
// Optional WAIT timeout is enabled with `define MAZE_FRAME_DRIVER_TIMEOUT_EN.
module maze_frame_driver #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int MAZE_DIM    = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_row,
    input  logic [14:0] wr_data,
    input  logic        start,
    output logic        maze,
    output logic        in_valid,
    input  logic        out_valid,
    input  logic        maze_not_valid,
    input  logic [3:0]  out_x,
    input  logic [3:0]  out_y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        no_path,
    output logic [7:0]  path_len,
    output logic [3:0]  err
);
    localparam logic [3:0] LAST = 4'(MAZE_DIM - 1);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 8191) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit the 13-bit wait counter");
    end

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

    state_t      state, state_nx;
    logic [14:0] image [15];
    logic [3:0]  row_cnt, col_cnt;
    logic [3:0]  prev_x, prev_y;
    logic        pass_q;
    logic        timed_out;
    logic [14:0] row_bits;
    logic        cell_open;
    logic signed [4:0] dx, dy;
    logic        step_ok;

    function automatic logic [4:0] abs5(input logic signed [4:0] v);
        return v[4] ? 5'(-v) : 5'(v);
    endfunction

    // Response cell lookup; row or column 15 reads as wall.
    always_comb begin
        row_bits = '1;
        for (int r = 0; r < 15; r++)
            if (out_y == 4'(r)) row_bits = image[r];
    end

    assign cell_open = (out_x != 4'd15) && !row_bits[out_x];
    assign dx        = $signed({1'b0, out_x}) - $signed({1'b0, prev_x});
    assign dy        = $signed({1'b0, out_y}) - $signed({1'b0, prev_y});
    assign step_ok   = (abs5(dx) + abs5(dy)) == 5'd1;

`ifdef MAZE_FRAME_DRIVER_TIMEOUT_EN
    logic [12:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              to_cnt <= '0;
        else if (state == S_WAIT) to_cnt <= to_cnt + 13'd1;
        else                      to_cnt <= '0;
    end

    assign timed_out = (state == S_WAIT) && !out_valid && (to_cnt == 13'(TIMEOUT_CYC - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_SEND;
            S_SEND: if (row_cnt == LAST && col_cnt == LAST) state_nx = S_WAIT;
            S_WAIT: begin
                if (out_valid)      state_nx = maze_not_valid ? S_DONE : S_RECV;
                else if (timed_out) state_nx = S_DONE;
            end
            S_RECV: if (!out_valid) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_valid = (state == S_SEND);
        maze     = (state == S_SEND) ? image[row_cnt][col_cnt] : 1'b0;
        busy     = (state == S_SEND) || (state == S_WAIT) || (state == S_RECV);
        done     = (state == S_DONE);
        pass     = (state == S_DONE) ? (err == 4'd0) : pass_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 15; r++) image[r] <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            prev_x   <= '0;
            prev_y   <= '0;
            pass_q   <= 1'b0;
            no_path  <= 1'b0;
            path_len <= '0;
            err      <= '0;
        end else begin
            if (wr_en && wr_row <= LAST) image[wr_row] <= wr_data;
            case (state)
                S_IDLE: if (start) begin
                    err      <= '0;
                    pass_q   <= 1'b0;
                    no_path  <= 1'b0;
                    path_len <= '0;
                    row_cnt  <= '0;
                    col_cnt  <= '0;
                end
                S_SEND: begin
                    if (col_cnt == LAST) begin
                        col_cnt <= '0;
                        row_cnt <= row_cnt + 4'd1;
                    end else begin
                        col_cnt <= col_cnt + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (out_valid && maze_not_valid) begin
                        no_path <= 1'b1;
                    end else if (out_valid) begin
                        // First path beat arrives here and is checked as beat 0.
                        path_len <= 8'd1;
                        prev_x   <= out_x;
                        prev_y   <= out_y;
                        if (out_x != 4'd13 || out_y != 4'd13) err[0] <= 1'b1;
                        if (!cell_open) err[1] <= 1'b1;
                    end else if (maze_not_valid || timed_out) begin
                        err[3] <= 1'b1;
                    end
                end
                S_RECV: begin
                    if (maze_not_valid) err[3] <= 1'b1;
                    if (out_valid) begin
                        if (path_len != 8'hFF) path_len <= path_len + 8'd1;
                        if (!cell_open || !step_ok) err[1] <= 1'b1;
                        prev_x <= out_x;
                        prev_y <= out_y;
                    end else if (prev_x != 4'd1 || prev_y != 4'd1) begin
                        err[2] <= 1'b1;
                    end
                end
                S_DONE: pass_q <= (err == 4'd0);
                default: ;
            endcase
        end
    end
endmodule
